// File: rtl/turn_signal_seq.sv
// Turn-signal / hazard / brake lamp sequencer with integrated step prescaler.
// Drives LAMPS lamps per side; bit 0 is the lamp nearest the centre.
module turn_signal_seq #(
  parameter int unsigned LAMPS = 3,
  parameter int unsigned DIV   = 25000000,
  parameter int unsigned DIV_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] L,
  output logic [LAMPS-1:0] R,
  output logic             busy
);

  localparam int unsigned STEP_W = $clog2(LAMPS + 1);
  localparam logic [DIV_W-1:0]  CNT_MAX  = DIV_W'(DIV - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LAMPS);

  typedef enum logic [2:0] {
    IDLE,
    LSEQ,
    RSEQ,
    HAZ_ON,
    HAZ_OFF
  } state_t;

  state_t            state, state_nx;
  logic [STEP_W-1:0] step, step_nx;
  logic [DIV_W-1:0]  cnt;
  logic              brake_q;
  logic              tick;
  logic              haz_req;
  logic              side_req;
  logic [LAMPS-1:0]  therm;
  logic [LAMPS-1:0]  brake_all;

  assign haz_req  = hazard | (left & right);
  assign side_req = (state == LSEQ) ? left : right;
  assign tick     = (state != IDLE) && (cnt == CNT_MAX);

  // Prescaler is held at zero while idle, so every sequence starts with a full phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      step    <= '0;
      cnt     <= '0;
      brake_q <= 1'b0;
    end else begin
      state   <= state_nx;
      step    <= step_nx;
      brake_q <= brake;
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      IDLE: begin
        if (haz_req) begin
          state_nx = HAZ_ON;
          step_nx  = '0;
        end else if (left) begin
          state_nx = LSEQ;
          step_nx  = STEP_W'(1);
        end else if (right) begin
          state_nx = RSEQ;
          step_nx  = STEP_W'(1);
        end
      end
      LSEQ, RSEQ: begin
        if (tick) begin
          if (haz_req) begin
            state_nx = HAZ_ON;
            step_nx  = '0;
          end else if (step == STEP_MAX) begin
            step_nx = '0;
          end else if (step == '0) begin
            // All-off phase done: repeat only if this side is still requested.
            if (side_req) step_nx = STEP_W'(1);
            else          state_nx = IDLE;
          end else begin
            step_nx = step + 1'b1;
          end
        end
      end
      HAZ_ON: begin
        if (tick) state_nx = HAZ_OFF;
      end
      HAZ_OFF: begin
        if (tick) state_nx = haz_req ? HAZ_ON : IDLE;
      end
      default: begin
        state_nx = IDLE;
        step_nx  = '0;
      end
    endcase
  end

  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < LAMPS; i++) begin
      therm[i] = (STEP_W'(i) < step);
    end
  end

  assign brake_all = {LAMPS{brake_q}};

  always_comb begin
    L = '0;
    R = '0;
    case (state)
      LSEQ: begin
        L = therm;
        R = brake_all;
      end
      RSEQ: begin
        L = brake_all;
        R = therm;
      end
      HAZ_ON: begin
        L = '1;
        R = '1;
      end
      HAZ_OFF: begin
        L = '0;
        R = '0;
      end
      default: begin
        L = brake_all;
        R = brake_all;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_turn_signal_seq.sv
// Directed bench for turn_signal_seq: LAMPS=3/DIV=4 main instance plus LAMPS=5/DIV=1 instance.
module tb_turn_signal_seq;

  logic       clk;
  logic       rst;
  logic       left;
  logic       right;
  logic       hazard;
  logic       brake;
  logic [2:0] lamp_l;
  logic [2:0] lamp_r;
  logic       busy;
  logic [4:0] fast_l;
  logic [4:0] fast_r;
  logic       fast_busy;

  int checks;
  int errors;

  logic [2:0] pat3 [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
  logic [4:0] pat5 [6] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000};

  turn_signal_seq #(.LAMPS(3), .DIV(4), .DIV_W(3)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .left   (left),
    .right  (right),
    .hazard (hazard),
    .brake  (brake),
    .L      (lamp_l),
    .R      (lamp_r),
    .busy   (busy)
  );

  turn_signal_seq #(.LAMPS(5), .DIV(1), .DIV_W(1)) u_fast (
    .clk    (clk),
    .rst    (rst),
    .left   (left),
    .right  (right),
    .hazard (hazard),
    .brake  (brake),
    .L      (fast_l),
    .R      (fast_r),
    .busy   (fast_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    left   = 1'b0;
    right  = 1'b0;
    hazard = 1'b0;
    brake  = 1'b0;

    // Reset state
    step_clk();
    step_clk();
    chk_eq("rst_L", 32'(lamp_l), 32'd0);
    chk_eq("rst_R", 32'(lamp_r), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step_clk();
    chk_eq("idle_busy", 32'(busy), 32'd0);

    // 1: left held 40 cycles, then released; sequence completes before IDLE
    left = 1'b1;
    for (int n = 1; n <= 48; n++) begin
      step_clk();
      if (n == 40) left = 1'b0;
      chk_eq("t1_L", 32'(lamp_l), 32'(pat3[((n - 1) / 4) % 4]));
      chk_eq("t1_R", 32'(lamp_r), 32'd0);
      chk_eq("t1_busy", 32'(busy), 32'd1);
    end
    step_clk();
    chk_eq("t1_end_busy", 32'(busy), 32'd0);
    chk_eq("t1_end_L", 32'(lamp_l), 32'd0);

    // 2: right pulsed one cycle -> one full sequence
    right = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step_clk();
      right = 1'b0;
      chk_eq("t2_R", 32'(lamp_r), 32'(pat3[(n - 1) / 4]));
      chk_eq("t2_L", 32'(lamp_l), 32'd0);
      chk_eq("t2_busy", 32'(busy), 32'd1);
    end
    step_clk();
    chk_eq("t2_end_busy", 32'(busy), 32'd0);
    chk_eq("t2_end_R", 32'(lamp_r), 32'd0);

    // 3: left&right together -> hazard flashing; dropped during HAZ_ON
    left  = 1'b1;
    right = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step_clk();
      if (n == 10) begin
        left  = 1'b0;
        right = 1'b0;
      end
      chk_eq("t3_L", 32'(lamp_l), (((n - 1) / 4) % 2 == 0) ? 32'd7 : 32'd0);
      chk_eq("t3_R", 32'(lamp_r), (((n - 1) / 4) % 2 == 0) ? 32'd7 : 32'd0);
      chk_eq("t3_busy", 32'(busy), 32'd1);
    end
    step_clk();
    chk_eq("t3_end_busy", 32'(busy), 32'd0);

    // 4: brake during RSEQ, then brake in IDLE
    right = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step_clk();
      chk_eq("t4_R", 32'(lamp_r), 32'(pat3[(n - 1) / 4]));
      chk_eq("t4_L", 32'(lamp_l), (n >= 3) ? 32'd7 : 32'd0);
      if (n == 2) brake = 1'b1;
      if (n == 5) right = 1'b0;
    end
    step_clk();
    chk_eq("t4_idle_busy", 32'(busy), 32'd0);
    chk_eq("t4_idle_L", 32'(lamp_l), 32'd7);
    chk_eq("t4_idle_R", 32'(lamp_r), 32'd7);
    brake = 1'b0;
    step_clk();
    chk_eq("t4_off_L", 32'(lamp_l), 32'd0);
    chk_eq("t4_off_R", 32'(lamp_r), 32'd0);

    // 5: hazard raised at LSEQ step 2 preempts on the next tick
    left = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step_clk();
      chk_eq("t5_L", 32'(lamp_l), 32'(pat3[(n - 1) / 4]));
      chk_eq("t5_R", 32'(lamp_r), 32'd0);
      if (n == 6) hazard = 1'b1;
    end
    for (int n = 9; n <= 16; n++) begin
      step_clk();
      if (n == 9) begin
        hazard = 1'b0;
        left   = 1'b0;
      end
      chk_eq("t5_haz_L", 32'(lamp_l), (n <= 12) ? 32'd7 : 32'd0);
      chk_eq("t5_haz_R", 32'(lamp_r), (n <= 12) ? 32'd7 : 32'd0);
      chk_eq("t5_busy", 32'(busy), 32'd1);
    end
    step_clk();
    chk_eq("t5_end_busy", 32'(busy), 32'd0);

    // 6: async reset mid-LSEQ
    left = 1'b1;
    for (int n = 1; n <= 6; n++) step_clk();
    chk_eq("t6_pre_L", 32'(lamp_l), 32'd3);
    rst = 1'b0;
    #1;
    chk_eq("t6_rst_L", 32'(lamp_l), 32'd0);
    chk_eq("t6_rst_R", 32'(lamp_r), 32'd0);
    chk_eq("t6_rst_busy", 32'(busy), 32'd0);
    chk_eq("t6_rst_fast_busy", 32'(fast_busy), 32'd0);
    left = 1'b0;
    step_clk();
    chk_eq("t6_hold_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step_clk();
    chk_eq("t6_rel_busy", 32'(busy), 32'd0);
    chk_eq("t6_rel_L", 32'(lamp_l), 32'd0);

    // 6b: DIV=1, LAMPS=5 -> one thermometer step per clock
    left = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step_clk();
      if (n == 7) left = 1'b0;
      if (n <= 7) chk_eq("t6b_L", 32'(fast_l), 32'(pat5[(n - 1) % 6]));
      chk_eq("t6b_R", 32'(fast_r), 32'd0);
      chk_eq("t6b_busy", 32'(fast_busy), 32'd1);
    end
    step_clk();
    chk_eq("t6b_end_busy", 32'(fast_busy), 32'd0);
    chk_eq("t6b_end_L", 32'(fast_l), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
